// File: rtl/tdc_interval_measure.sv
// Start/stop interval measurement: pairs a start hit with the next stop hit and reports
// elapsed*TAPS_PER_CYCLE + F_start - F_stop on a single-entry valid/ready output register.
module tdc_interval_measure #(
    parameter int unsigned FINE_WIDTH     = 9,
    parameter int unsigned TAPS_PER_CYCLE = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned OUT_WIDTH      = 26
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_N,
    input  logic                  i_Start_Valid,
    input  logic [FINE_WIDTH-1:0] i_Start_Fine,
    input  logic                  i_Stop_Valid,
    input  logic [FINE_WIDTH-1:0] i_Stop_Fine,
    output logic                  o_Meas_Valid,
    input  logic                  i_Meas_Ready,
    output logic [OUT_WIDTH-1:0]  o_Meas_Interval,
    output logic                  o_Meas_Timeout,
    output logic [7:0]            o_Drop_Count,
    output logic                  o_Busy
);

    typedef enum logic [1:0] {StIdle, StArmed, StHold} state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  elapsed_q;
    logic [FINE_WIDTH-1:0] start_fine_q;
    logic                  meas_valid_q;
    logic [OUT_WIDTH-1:0]  interval_q;
    logic                  timeout_q;
    logic [7:0]            drop_count_q;
    logic                  busy_q;

    // The register is cleared on capture, so the elapsed count for the current cycle is one more.
    logic [CNT_WIDTH-1:0]  elapsed_now;
    logic [OUT_WIDTH-1:0]  armed_interval;
    logic [OUT_WIDTH-1:0]  same_cycle_interval;
    logic                  timeout_hit;

    assign elapsed_now         = elapsed_q + CNT_WIDTH'(1);
    assign armed_interval      = OUT_WIDTH'(elapsed_now) * OUT_WIDTH'(TAPS_PER_CYCLE)
                                 + OUT_WIDTH'(start_fine_q) - OUT_WIDTH'(i_Stop_Fine);
    assign same_cycle_interval = OUT_WIDTH'(i_Start_Fine) - OUT_WIDTH'(i_Stop_Fine);
    assign timeout_hit         = (elapsed_now == CNT_WIDTH'(TIMEOUT_CYCLES));

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_N) begin
            state_q      <= StIdle;
            elapsed_q    <= '0;
            start_fine_q <= '0;
            meas_valid_q <= 1'b0;
            interval_q   <= '0;
            timeout_q    <= 1'b0;
            drop_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_Start_Valid) begin
                        start_fine_q <= i_Start_Fine;
                        elapsed_q    <= '0;
                        busy_q       <= 1'b1;
                        // A same-cycle stop with a larger fine code happened before the start.
                        if (i_Stop_Valid && (i_Stop_Fine <= i_Start_Fine)) begin
                            interval_q   <= same_cycle_interval;
                            timeout_q    <= 1'b0;
                            meas_valid_q <= 1'b1;
                            state_q      <= StHold;
                        end else begin
                            state_q <= StArmed;
                        end
                    end
                end
                StArmed: begin
                    elapsed_q <= elapsed_now;
                    if (i_Stop_Valid) begin
                        interval_q   <= armed_interval;
                        timeout_q    <= 1'b0;
                        meas_valid_q <= 1'b1;
                        state_q      <= StHold;
                    end else if (timeout_hit) begin
                        interval_q   <= '0;
                        timeout_q    <= 1'b1;
                        meas_valid_q <= 1'b1;
                        state_q      <= StHold;
                    end
                end
                StHold: begin
                    if (i_Start_Valid && (drop_count_q != 8'hFF)) begin
                        drop_count_q <= drop_count_q + 8'd1;
                    end
                    if (meas_valid_q && i_Meas_Ready) begin
                        meas_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Meas_Valid    = meas_valid_q;
    assign o_Meas_Interval = interval_q;
    assign o_Meas_Timeout  = timeout_q;
    assign o_Drop_Count    = drop_count_q;
    assign o_Busy          = busy_q;

endmodule
